// File: rtl/sram_arbiter.sv
// Shares one single-port scratchpad SRAM between NPORTS requesters.
// Round-robin or fixed-priority-with-aging arbitration; grants are blocked while the SRAM is unavailable.
module sram_arbiter #(
  parameter int NPORTS = 3,
  parameter int AGE_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NPORTS-1:0]      req,
  input  logic [NPORTS-1:0]      we,
  input  logic [4*NPORTS-1:0]    be,
  input  logic [13*NPORTS-1:0]   addr,
  input  logic [32*NPORTS-1:0]   wdata,
  output logic [NPORTS-1:0]      gnt,
  output logic [NPORTS-1:0]      rvalid,
  output logic [31:0]            rdata,
  input  logic                   arb_mode,
  input  logic [AGE_W-1:0]       age_limit,
  input  logic                   mbist_en,
  input  logic                   pd_en,
  input  logic                   ret_en,
  output logic                   sram_req,
  output logic                   sram_we,
  output logic [3:0]             sram_be,
  output logic [12:0]            sram_addr,
  output logic [31:0]            sram_wdata,
  input  logic [31:0]            sram_rdata,
  input  logic                   sram_ready
);

  localparam int IDX_W = $clog2(NPORTS);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic                 blocked;
  logic [NPORTS-1:0]    elig;
  logic [NPORTS-1:0]    aged;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_found;
  logic [AGE_W-1:0]     age [NPORTS];

  always_comb begin
    blocked = mbist_en | ~pd_en | ret_en | ~sram_ready;
    elig    = blocked ? '0 : req;
    for (int k = 0; k < NPORTS; k++) begin
      aged[k] = (age_limit != '0) && (age[k] >= age_limit);
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    if (!arb_mode) begin
      for (int i = 1; i <= NPORTS; i++) begin
        idx = (int'(ptr) + i) % NPORTS;
        if (!win_found && elig[idx]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(idx);
        end
      end
    end else if (|(elig & aged)) begin
      // Descending scan so the lowest aged index is the last one written.
      for (int k = NPORTS - 1; k >= 0; k--) begin
        if (elig[k] && aged[k]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(k);
        end
      end
    end else begin
      for (int k = NPORTS - 1; k >= 0; k--) begin
        if (elig[k]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(k);
        end
      end
    end
  end

  always_comb begin
    gnt        = '0;
    sram_we    = 1'b0;
    sram_be    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (win_found) begin
      gnt[win_idx] = 1'b1;
      sram_we      = we[win_idx];
      sram_be      = be[4*win_idx +: 4];
      sram_addr    = addr[13*win_idx +: 13];
      sram_wdata   = wdata[32*win_idx +: 32];
    end
    sram_req = win_found;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= IDX_W'(NPORTS - 1);
      rvalid <= '0;
      rdata  <= '0;
      for (int k = 0; k < NPORTS; k++) begin
        age[k] <= '0;
      end
    end else begin
      if (win_found) begin
        ptr <= win_idx;
      end
      rvalid <= (sram_req && !sram_we) ? gnt : '0;
      if (sram_req && !sram_we) begin
        rdata <= sram_rdata;
      end
      for (int k = 0; k < NPORTS; k++) begin
        if (!req[k] || gnt[k]) begin
          age[k] <= '0;
        end else if (age[k] != AGE_MAX) begin
          age[k] <= age[k] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: inputs change on the falling edge, outputs are checked 1 ns later.
module tb_sram_arbiter;

  localparam int NPORTS = 3;
  localparam int AGE_W  = 4;

  logic                 clk;
  logic                 rst;
  logic [NPORTS-1:0]    req;
  logic [NPORTS-1:0]    we;
  logic [4*NPORTS-1:0]  be;
  logic [13*NPORTS-1:0] addr;
  logic [32*NPORTS-1:0] wdata;
  logic [NPORTS-1:0]    gnt;
  logic [NPORTS-1:0]    rvalid;
  logic [31:0]          rdata;
  logic                 arb_mode;
  logic [AGE_W-1:0]     age_limit;
  logic                 mbist_en;
  logic                 pd_en;
  logic                 ret_en;
  logic                 sram_req;
  logic                 sram_we;
  logic [3:0]           sram_be;
  logic [12:0]          sram_addr;
  logic [31:0]          sram_wdata;
  logic [31:0]          sram_rdata;
  logic                 sram_ready;

  int total = 0;
  int bad   = 0;

  sram_arbiter #(.NPORTS(NPORTS), .AGE_W(AGE_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .we         (we),
    .be         (be),
    .addr       (addr),
    .wdata      (wdata),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .arb_mode   (arb_mode),
    .age_limit  (age_limit),
    .mbist_en   (mbist_en),
    .pd_en      (pd_en),
    .ret_en     (ret_en),
    .sram_req   (sram_req),
    .sram_we    (sram_we),
    .sram_be    (sram_be),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_ready (sram_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_reqs();
    req   = '0;
    we    = '0;
    be    = '0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic set_port(input int k, input logic w, input logic [3:0] b,
                          input logic [12:0] a, input logic [31:0] d);
    req[k]          = 1'b1;
    we[k]           = w;
    be[4*k +: 4]    = b;
    addr[13*k +: 13] = a;
    wdata[32*k +: 32] = d;
  endtask

  initial begin
    logic [2:0] exp_g;
    rst        = 1'b1;
    arb_mode   = 1'b0;
    age_limit  = '0;
    mbist_en   = 1'b0;
    pd_en      = 1'b1;
    ret_en     = 1'b0;
    sram_ready = 1'b1;
    sram_rdata = '0;
    clear_reqs();

    // Reset state
    #1;
    check("rst_rvalid", 64'(rvalid), 64'h0);
    check("rst_rdata", 64'(rdata), 64'h0);
    check("rst_gnt", 64'(gnt), 64'h0);
    check("rst_sram_req", 64'(sram_req), 64'h0);
    check("rst_sram_addr", 64'(sram_addr), 64'h0);

    // Single read on port 1
    @(negedge clk);
    rst = 1'b0;
    set_port(1, 1'b0, 4'hF, 13'h010, 32'h0);
    sram_rdata = 32'hDEADBEEF;
    #1;
    check("rd_gnt", 64'(gnt), 64'h2);
    check("rd_sram_req", 64'(sram_req), 64'h1);
    check("rd_sram_addr", 64'(sram_addr), 64'h010);
    check("rd_sram_we", 64'(sram_we), 64'h0);
    @(negedge clk);
    clear_reqs();
    sram_rdata = 32'h12345678;
    #1;
    check("rd_rvalid", 64'(rvalid), 64'h2);
    check("rd_rdata", 64'(rdata), 64'hDEADBEEF);
    check("idle_gnt", 64'(gnt), 64'h0);
    @(negedge clk);
    #1;
    check("rd_rvalid_one_cycle", 64'(rvalid), 64'h0);
    check("rd_rdata_hold", 64'(rdata), 64'hDEADBEEF);

    // Round-robin, all three ports requesting (fresh reset so port 0 leads)
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int k = 0; k < NPORTS; k++) set_port(k, 1'b0, 4'hF, 13'(k * 4), 32'h0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_g = 3'(1 << (i % 3));
      check("rr_gnt", 64'(gnt), 64'(exp_g));
      if (i > 0) begin
        exp_g = 3'(1 << ((i - 1) % 3));
        check("rr_rvalid", 64'(rvalid), 64'(exp_g));
      end
    end
    @(negedge clk);
    clear_reqs();
    #1;
    check("rr_last_rvalid", 64'(rvalid), 64'h4);

    // Fixed priority with aging, limit 3: pattern 0,0,0,2
    @(negedge clk);
    arb_mode  = 1'b1;
    age_limit = 4'd3;
    set_port(0, 1'b0, 4'hF, 13'h100, 32'h0);
    set_port(2, 1'b0, 4'hF, 13'h200, 32'h0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_g = (i % 4 == 3) ? 3'b100 : 3'b001;
      check("age3_gnt", 64'(gnt), 64'(exp_g));
    end

    // Aging disabled: port 2 starves while its age saturates at 15
    @(negedge clk);
    age_limit = '0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check("age0_gnt", 64'(gnt), 64'h1);
    end
    @(negedge clk);
    age_limit = 4'd15;
    #1;
    check("age_saturate_gnt", 64'(gnt), 64'h4);
    @(negedge clk);
    clear_reqs();

    // Port 0 partial write
    @(negedge clk);
    set_port(0, 1'b1, 4'b0101, 13'h004, 32'h11223344);
    #1;
    check("wr_gnt", 64'(gnt), 64'h1);
    check("wr_sram_we", 64'(sram_we), 64'h1);
    check("wr_sram_be", 64'(sram_be), 64'h5);
    check("wr_sram_addr", 64'(sram_addr), 64'h004);
    check("wr_sram_wdata", 64'(sram_wdata), 64'h11223344);
    @(negedge clk);
    clear_reqs();
    #1;
    check("wr_no_rvalid", 64'(rvalid), 64'h0);

    // Blocking: SRAM not ready, then MBIST for 5 cycles
    @(negedge clk);
    arb_mode = 1'b0;
    set_port(1, 1'b0, 4'hF, 13'h020, 32'h0);
    sram_ready = 1'b0;
    sram_rdata = 32'h0BADF00D;
    #1;
    check("notready_gnt", 64'(gnt), 64'h0);
    @(negedge clk);
    sram_ready = 1'b1;
    mbist_en   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check("mbist_gnt", 64'(gnt), 64'h0);
      check("mbist_sram_req", 64'(sram_req), 64'h0);
      check("mbist_sram_addr", 64'(sram_addr), 64'h0);
    end
    @(negedge clk);
    mbist_en = 1'b0;
    #1;
    check("post_mbist_gnt", 64'(gnt), 64'h2);
    @(negedge clk);
    clear_reqs();
    #1;
    check("post_mbist_rvalid", 64'(rvalid), 64'h2);
    check("post_mbist_rdata", 64'(rdata), 64'h0BADF00D);

    // Reset right after a read grant drops the response
    @(negedge clk);
    set_port(0, 1'b0, 4'hF, 13'h040, 32'h0);
    sram_rdata = 32'hCAFEF00D;
    #1;
    check("pre_rst_gnt", 64'(gnt), 64'h1);
    @(negedge clk);
    clear_reqs();
    rst = 1'b1;
    #1;
    check("mid_rst_rvalid", 64'(rvalid), 64'h0);
    check("mid_rst_rdata", 64'(rdata), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NPORTS; k++) set_port(k, 1'b0, 4'hF, 13'h0, 32'h0);
    #1;
    check("post_rst_rr_gnt", 64'(gnt), 64'h1);
    @(negedge clk);
    clear_reqs();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
